// File: rtl/pxy_arbiter.sv
// -----------------------------------------------------------------------------
// pxy_arbiter
//
// Two-requester arbiter for a shared peripheral proxy bus. Requester 0 is the
// EU SFR proxy path, requester 1 the debug/loader master. Each transaction runs
// IDLE -> SETUP -> STROBE -> DONE -> IDLE. In SETUP the address and write data
// are presented. In STROBE a single-cycle PXY_WR or PXY_RD pulse is issued. In
// DONE the winner gets a one-cycle READY, with read data on its RDATA.
//
// Configuration macro:
//   PXY_ARB_RR_EN  defined   -> simultaneous requests granted round-robin
//                  undefined -> requester 0 always wins simultaneous requests
//
// Ports:
//   CORE_CLK, RST_n            clock, asynchronous active-low reset
//   Mx_VALID/WR/ADDR/WDATA     requester x transaction request (held until READY)
//   Mx_READY, Mx_RDATA         requester x completion pulse and read data
//   PXY_ADDR, PXY_DOUT         shared peripheral address / write data
//   PXY_WR, PXY_RD             peripheral write / read strobes
//   PXY_DIN                    peripheral read data (combinational from PXY_ADDR)
//   ARB_GNT                    one-hot bus owner, 00 when idle
// -----------------------------------------------------------------------------
module pxy_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CORE_CLK,
    input  logic              RST_n,
    input  logic              M0_VALID,
    input  logic              M0_WR,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic [DATA_W-1:0] M0_WDATA,
    output logic              M0_READY,
    output logic [DATA_W-1:0] M0_RDATA,
    input  logic              M1_VALID,
    input  logic              M1_WR,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic [DATA_W-1:0] M1_WDATA,
    output logic              M1_READY,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic [ADDR_W-1:0] PXY_ADDR,
    output logic [DATA_W-1:0] PXY_DOUT,
    output logic              PXY_WR,
    output logic              PXY_RD,
    input  logic [DATA_W-1:0] PXY_DIN,
    output logic [1:0]        ARB_GNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q;
    logic              wr_q;
    logic [1:0]        gnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              pxy_wr_q;
    logic              pxy_rd_q;
    logic              m0_ready_q;
    logic              m1_ready_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

`ifdef PXY_ARB_RR_EN
    // 1 when requester 1 was granted most recently.
    logic              last_q;
`endif

    // Winner selection, only consumed in IDLE.
    logic              win1;
    logic              any_valid;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        any_valid = M0_VALID | M1_VALID;
`ifdef PXY_ARB_RR_EN
        // On contention the requester not served last wins.
        win1 = M1_VALID & (~M0_VALID | ~last_q);
`else
        win1 = M1_VALID & ~M0_VALID;
`endif
        sel_wr    = win1 ? M1_WR    : M0_WR;
        sel_addr  = win1 ? M1_ADDR  : M0_ADDR;
        sel_wdata = win1 ? M1_WDATA : M0_WDATA;
    end

    always_ff @(posedge CORE_CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            wr_q       <= 1'b0;
            gnt_q      <= 2'b00;
            addr_q     <= '0;
            dout_q     <= '0;
            pxy_wr_q   <= 1'b0;
            pxy_rd_q   <= 1'b0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifdef PXY_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        wr_q    <= sel_wr;
                        addr_q  <= sel_addr;
                        dout_q  <= sel_wdata;
                        gnt_q   <= win1 ? 2'b10 : 2'b01;
`ifdef PXY_ARB_RR_EN
                        last_q  <= win1;
`endif
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    pxy_wr_q <= wr_q;
                    pxy_rd_q <= ~wr_q;
                    state_q  <= STROBE;
                end
                STROBE: begin
                    pxy_wr_q   <= 1'b0;
                    pxy_rd_q   <= 1'b0;
                    m0_ready_q <= gnt_q[0];
                    m1_ready_q <= gnt_q[1];
                    // Read data is sampled at the end of the strobe cycle.
                    if (!wr_q) begin
                        if (gnt_q[1]) begin
                            m1_rdata_q <= PXY_DIN;
                        end else begin
                            m0_rdata_q <= PXY_DIN;
                        end
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    m0_ready_q <= 1'b0;
                    m1_ready_q <= 1'b0;
                    gnt_q      <= 2'b00;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PXY_ADDR = addr_q;
    assign PXY_DOUT = dout_q;
    assign PXY_WR   = pxy_wr_q;
    assign PXY_RD   = pxy_rd_q;
    assign ARB_GNT  = gnt_q;
    assign M0_READY = m0_ready_q;
    assign M1_READY = m1_ready_q;
    assign M0_RDATA = m0_rdata_q;
    assign M1_RDATA = m1_rdata_q;

endmodule

// File: tb/tb_pxy_arbiter.sv
module tb_pxy_arbiter;

    logic       CORE_CLK;
    logic       RST_n;
    logic       M0_VALID, M0_WR, M0_READY;
    logic [7:0] M0_ADDR, M0_WDATA, M0_RDATA;
    logic       M1_VALID, M1_WR, M1_READY;
    logic [7:0] M1_ADDR, M1_WDATA, M1_RDATA;
    logic [7:0] PXY_ADDR, PXY_DOUT, PXY_DIN;
    logic       PXY_WR, PXY_RD;
    logic [1:0] ARB_GNT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         who;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    // Peripheral model: read data is a fixed function of the address.
    assign PXY_DIN = PXY_ADDR ^ 8'h5F;

    pxy_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .CORE_CLK(CORE_CLK), .RST_n(RST_n),
        .M0_VALID(M0_VALID), .M0_WR(M0_WR), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_READY(M0_READY), .M0_RDATA(M0_RDATA),
        .M1_VALID(M1_VALID), .M1_WR(M1_WR), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_READY(M1_READY), .M1_RDATA(M1_RDATA),
        .PXY_ADDR(PXY_ADDR), .PXY_DOUT(PXY_DOUT), .PXY_WR(PXY_WR), .PXY_RD(PXY_RD),
        .PXY_DIN(PXY_DIN), .ARB_GNT(ARB_GNT)
    );

    initial CORE_CLK = 1'b0;
    always #5 CORE_CLK = ~CORE_CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every strobe must match the oldest pending
    // transaction and every READY retires it.
    always @(negedge CORE_CLK) begin
        if (RST_n) begin
            checks++;
            if (PXY_WR && PXY_RD) begin
                errors++;
                $display("FAIL strobe_excl: PXY_WR=%b PXY_RD=%b, must not both be 1", PXY_WR, PXY_RD);
            end
            if (PXY_WR || PXY_RD) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: wr=%b rd=%b addr=%h with no pending transaction",
                             PXY_WR, PXY_RD, PXY_ADDR);
                end else begin
                    me = sb[0];
                    if (PXY_WR !== me.wr || PXY_RD !== !me.wr || ARB_GNT !== (me.who == 1 ? 2'b10 : 2'b01) ||
                        PXY_ADDR !== me.addr || (me.wr && PXY_DOUT !== me.wdata)) begin
                        errors++;
                        $display("FAIL sb_strobe: wr=%b rd=%b gnt=%b addr=%h dout=%h, expected wr=%b gnt owner M%0d addr=%h dout=%h",
                                 PXY_WR, PXY_RD, ARB_GNT, PXY_ADDR, PXY_DOUT, me.wr, me.who, me.addr, me.wdata);
                    end
                end
            end
            if (M0_READY || M1_READY) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: M0_READY=%b M1_READY=%b with no pending transaction",
                             M0_READY, M1_READY);
                end else begin
                    me = sb.pop_front();
                    if ((me.who == 0 && !(M0_READY && !M1_READY)) || (me.who == 1 && !(M1_READY && !M0_READY)) ||
                        (!me.wr && me.who == 0 && M0_RDATA !== me.rdata) ||
                        (!me.wr && me.who == 1 && M1_RDATA !== me.rdata)) begin
                        errors++;
                        $display("FAIL sb_ready: M0_READY=%b M1_READY=%b M0_RDATA=%h M1_RDATA=%h, expected READY from M%0d rdata=%h (read=%b)",
                                 M0_READY, M1_READY, M0_RDATA, M1_RDATA, me.who, me.rdata, !me.wr);
                    end
                end
            end
        end
    end

    task automatic drive_req(input int who, input logic v, input logic wr,
                             input logic [7:0] addr, input logic [7:0] wdata);
        if (who == 0) begin
            M0_VALID = v; M0_WR = wr; M0_ADDR = addr; M0_WDATA = wdata;
        end else begin
            M1_VALID = v; M1_WR = wr; M1_ADDR = addr; M1_WDATA = wdata;
        end
    endtask

    task automatic push_exp(input int who, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        e.who = who; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = addr ^ 8'h5F;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        RST_n = 1'b1;
        drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        #1 RST_n = 1'b0;
        #2;
        checks++;
        if (PXY_WR !== 1'b0 || PXY_RD !== 1'b0 || M0_READY !== 1'b0 || M1_READY !== 1'b0 ||
            ARB_GNT !== 2'b00 || PXY_ADDR !== 8'h00 || PXY_DOUT !== 8'h00 ||
            M0_RDATA !== 8'h00 || M1_RDATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: wr=%b rd=%b r0=%b r1=%b gnt=%b addr=%h dout=%h rd0=%h rd1=%h, expected all 0",
                     PXY_WR, PXY_RD, M0_READY, M1_READY, ARB_GNT, PXY_ADDR, PXY_DOUT, M0_RDATA, M1_RDATA);
        end
        repeat (3) @(negedge CORE_CLK);
        RST_n = 1'b1;
        @(negedge CORE_CLK);
        checks++;
        if (ARB_GNT !== 2'b00 || PXY_WR !== 1'b0 || PXY_RD !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: gnt=%b wr=%b rd=%b, expected 00 0 0", ARB_GNT, PXY_WR, PXY_RD);
        end
    endtask

    // Single transaction with cycle-exact checks (VALID seen in cycle 0).
    task automatic run_single(input string name, input int who, input logic wr,
                              input logic [7:0] addr, input logic [7:0] wdata);
        logic [1:0] g;
        logic       rdy, other;
        g = (who == 1) ? 2'b10 : 2'b01;
        @(negedge CORE_CLK);
        drive_req(who, 1'b1, wr, addr, wdata);
        push_exp(who, wr, addr, wdata);
        @(negedge CORE_CLK);
        checks++;
        if (ARB_GNT !== g || PXY_ADDR !== addr || PXY_DOUT !== wdata || PXY_WR !== 1'b0 || PXY_RD !== 1'b0) begin
            errors++;
            $display("FAIL %s_setup: gnt=%b addr=%h dout=%h wr=%b rd=%b, expected gnt=%b addr=%h dout=%h wr=0 rd=0",
                     name, ARB_GNT, PXY_ADDR, PXY_DOUT, PXY_WR, PXY_RD, g, addr, wdata);
        end
        @(negedge CORE_CLK);
        checks++;
        if (PXY_WR !== wr || PXY_RD !== !wr || PXY_ADDR !== addr || PXY_DOUT !== wdata) begin
            errors++;
            $display("FAIL %s_strobe: wr=%b rd=%b addr=%h dout=%h, expected wr=%b rd=%b addr=%h dout=%h",
                     name, PXY_WR, PXY_RD, PXY_ADDR, PXY_DOUT, wr, !wr, addr, wdata);
        end
        @(negedge CORE_CLK);
        rdy   = (who == 1) ? M1_READY : M0_READY;
        other = (who == 1) ? M0_READY : M1_READY;
        checks++;
        if (rdy !== 1'b1 || other !== 1'b0 || PXY_WR !== 1'b0 || PXY_RD !== 1'b0 || PXY_ADDR !== addr) begin
            errors++;
            $display("FAIL %s_done: ready=%b other=%b wr=%b rd=%b addr=%h, expected ready=1 other=0 wr=0 rd=0 addr=%h",
                     name, rdy, other, PXY_WR, PXY_RD, PXY_ADDR, addr);
        end
        drive_req(who, 1'b0, wr, addr, wdata);
        @(negedge CORE_CLK);
        checks++;
        if (ARB_GNT !== 2'b00 || M0_READY !== 1'b0 || M1_READY !== 1'b0 || PXY_ADDR !== addr || PXY_DOUT !== wdata) begin
            errors++;
            $display("FAIL %s_idle: gnt=%b r0=%b r1=%b addr=%h dout=%h, expected 00 0 0 addr=%h dout=%h",
                     name, ARB_GNT, M0_READY, M1_READY, PXY_ADDR, PXY_DOUT, addr, wdata);
        end
    endtask

    task automatic test_single_write();
        run_single("m0_write", 0, 1'b1, 8'h12, 8'hA5);
    endtask

    task automatic test_single_read();
        run_single("m1_read", 1, 1'b0, 8'h03, 8'h00);
        checks++;
        if (M1_RDATA !== 8'h5C) begin
            errors++;
            $display("FAIL m1_read_data: M1_RDATA=%h, expected 5c", M1_RDATA);
        end
    endtask

    task automatic test_rdata_hold();
        run_single("m0_write2", 0, 1'b1, 8'h44, 8'h3C);
        checks++;
        if (M1_RDATA !== 8'h5C || M0_RDATA !== 8'h00) begin
            errors++;
            $display("FAIL hold_after_write: M0_RDATA=%h M1_RDATA=%h, expected 00 5c", M0_RDATA, M1_RDATA);
        end
        run_single("m0_read", 0, 1'b0, 8'h20, 8'h00);
        checks++;
        if (M0_RDATA !== 8'h7F || M1_RDATA !== 8'h5C) begin
            errors++;
            $display("FAIL hold_after_read: M0_RDATA=%h M1_RDATA=%h, expected 7f 5c", M0_RDATA, M1_RDATA);
        end
        run_single("m1_write", 1, 1'b1, 8'hF0, 8'h0F);
        checks++;
        if (M0_RDATA !== 8'h7F || M1_RDATA !== 8'h5C) begin
            errors++;
            $display("FAIL hold_after_m1_write: M0_RDATA=%h M1_RDATA=%h, expected 7f 5c", M0_RDATA, M1_RDATA);
        end
    endtask

    task automatic test_glitch();
        @(negedge CORE_CLK);
        drive_req(0, 1'b1, 1'b1, 8'h21, 8'h66);
        push_exp(0, 1'b1, 8'h21, 8'h66);
        @(negedge CORE_CLK);
        drive_req(1, 1'b1, 1'b1, 8'h99, 8'h11);
        @(negedge CORE_CLK);
        drive_req(1, 1'b0, 1'b1, 8'h99, 8'h11);
        @(negedge CORE_CLK);
        checks++;
        if (M0_READY !== 1'b1 || M1_READY !== 1'b0) begin
            errors++;
            $display("FAIL glitch_m0_done: M0_READY=%b M1_READY=%b, expected 1 0", M0_READY, M1_READY);
        end
        drive_req(0, 1'b0, 1'b1, 8'h21, 8'h66);
        for (int i = 0; i < 6; i++) begin
            @(negedge CORE_CLK);
            checks++;
            if (M1_READY !== 1'b0 || ARB_GNT !== 2'b00 || PXY_WR !== 1'b0 || PXY_RD !== 1'b0) begin
                errors++;
                $display("FAIL glitch_quiet: M1_READY=%b gnt=%b wr=%b rd=%b, expected 0 00 0 0",
                         M1_READY, ARB_GNT, PXY_WR, PXY_RD);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge CORE_CLK);
        drive_req(0, 1'b1, 1'b1, 8'h33, 8'h99);
        push_exp(0, 1'b1, 8'h33, 8'h99);
        @(negedge CORE_CLK);
        @(negedge CORE_CLK);
        checks++;
        if (PXY_WR !== 1'b1) begin
            errors++;
            $display("FAIL midrst_strobe: PXY_WR=%b, expected 1", PXY_WR);
        end
        #2 RST_n = 1'b0;
        sb.delete();
        drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        checks++;
        if (PXY_WR !== 1'b0 || PXY_RD !== 1'b0 || ARB_GNT !== 2'b00 || PXY_ADDR !== 8'h00 ||
            M0_READY !== 1'b0 || M0_RDATA !== 8'h00 || M1_RDATA !== 8'h00) begin
            errors++;
            $display("FAIL midrst_async: wr=%b rd=%b gnt=%b addr=%h r0=%b rd0=%h rd1=%h, expected all 0",
                     PXY_WR, PXY_RD, ARB_GNT, PXY_ADDR, M0_READY, M0_RDATA, M1_RDATA);
        end
        @(negedge CORE_CLK);
        @(negedge CORE_CLK);
        RST_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CORE_CLK);
            checks++;
            if (PXY_WR !== 1'b0 || PXY_RD !== 1'b0 || M0_READY !== 1'b0 || M1_READY !== 1'b0 ||
                ARB_GNT !== 2'b00 || PXY_ADDR !== 8'h00 || PXY_DOUT !== 8'h00 ||
                M0_RDATA !== 8'h00 || M1_RDATA !== 8'h00) begin
                errors++;
                $display("FAIL midrst_after: wr=%b rd=%b r0=%b r1=%b gnt=%b addr=%h dout=%h rd0=%h rd1=%h, expected all 0",
                         PXY_WR, PXY_RD, M0_READY, M1_READY, ARB_GNT, PXY_ADDR, PXY_DOUT, M0_RDATA, M1_RDATA);
            end
        end
    endtask

    // Both requesters hold VALID for two transactions each; M0 writes, M1 reads.
    task automatic test_contention();
        logic [1:0] order[$];
        logic [1:0] exp_order[4];
        logic [1:0] prev;
        int         m0n, m1n;
`ifdef PXY_ARB_RR_EN
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
        push_exp(0, 1'b1, 8'h40, 8'hC0);
        push_exp(1, 1'b0, 8'h80, 8'h00);
        push_exp(0, 1'b1, 8'h41, 8'hC1);
        push_exp(1, 1'b0, 8'h81, 8'h00);
`else
        exp_order = '{2'b01, 2'b01, 2'b10, 2'b10};
        push_exp(0, 1'b1, 8'h40, 8'hC0);
        push_exp(0, 1'b1, 8'h41, 8'hC1);
        push_exp(1, 1'b0, 8'h80, 8'h00);
        push_exp(1, 1'b0, 8'h81, 8'h00);
`endif
        m0n = 0; m1n = 0; prev = 2'b00;
        @(negedge CORE_CLK);
        drive_req(0, 1'b1, 1'b1, 8'h40, 8'hC0);
        drive_req(1, 1'b1, 1'b0, 8'h80, 8'h00);
        for (int cyc = 0; cyc < 80 && (m0n < 2 || m1n < 2); cyc++) begin
            @(negedge CORE_CLK);
            if (ARB_GNT != 2'b00 && prev == 2'b00) order.push_back(ARB_GNT);
            prev = ARB_GNT;
            if (M0_READY) begin
                m0n++;
                if (m0n == 2) drive_req(0, 1'b0, 1'b1, 8'h41, 8'hC1);
                else          drive_req(0, 1'b1, 1'b1, 8'h41, 8'hC1);
            end
            if (M1_READY) begin
                m1n++;
                if (m1n == 2) drive_req(1, 1'b0, 1'b0, 8'h81, 8'h00);
                else          drive_req(1, 1'b1, 1'b0, 8'h81, 8'h00);
            end
        end
        checks++;
        if (m0n != 2 || m1n != 2 || order.size() != 4) begin
            errors++;
            $display("FAIL contention_count: m0=%0d m1=%0d grants=%0d, expected 2 2 4", m0n, m1n, order.size());
        end
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            checks++;
            if (order[i] !== exp_order[i]) begin
                errors++;
                $display("FAIL contention_order[%0d]: gnt=%b, expected %b", i, order[i], exp_order[i]);
            end
        end
        @(negedge CORE_CLK);
        checks++;
        if (ARB_GNT !== 2'b00 || M1_RDATA !== (8'h81 ^ 8'h5F)) begin
            errors++;
            $display("FAIL contention_end: gnt=%b M1_RDATA=%h, expected 00 %h", ARB_GNT, M1_RDATA, 8'h81 ^ 8'h5F);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_rdata_hold();
        test_glitch();
        test_reset_mid();
        test_contention();
        repeat (3) @(negedge CORE_CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d transactions still pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
